// File: rtl/hwt_mon_pkg.sv
// Shared types, defaults and the reference function for the Y = D & ((A & B) | C) monitor.
package hwt_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MON   = 2'd1,
      ST_ALARM = 2'd2
   } mon_state_t;

   localparam int CNT_W_DEF  = 8;
   localparam int WINDOW_DEF = 16;
   localparam int THRESH_DEF = 4;

   function automatic logic golden_y(input logic a, input logic b, input logic c, input logic d);
      return d & ((a & b) | c);
   endfunction

endpackage

// File: rtl/hwt_window_ctr.sv
// Block-window mismatch counter; hit fires when the current block reaches the alarm threshold.
module hwt_window_ctr
   import hwt_mon_pkg::*;
#(
   parameter int WINDOW       = WINDOW_DEF,
   parameter int ALARM_THRESH = THRESH_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic cmp_vld,
   input  logic cmp_err,
   input  logic clr,
   output logic hit
);

   localparam int IW = $clog2(WINDOW);
   localparam int EW = $clog2(WINDOW + 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WINDOW - 1);
   localparam logic [EW-1:0] THR_M1   = EW'(ALARM_THRESH - 1);

   logic [IW-1:0] win_idx;
   logic [EW-1:0] win_err;

   // clear suppresses the hit even when it lands on the threshold-reaching mismatch
   assign hit = cmp_vld & cmp_err & ~clr & (win_err == THR_M1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_idx <= '0;
         win_err <= '0;
      end else if (clr) begin
         win_idx <= '0;
         win_err <= '0;
      end else if (cmp_vld) begin
         if (win_idx == IDX_LAST) begin
            win_idx <= '0;
            win_err <= '0;
         end else begin
            win_idx <= win_idx + 1'b1;
            if (cmp_err) win_err <= win_err + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hwt_output_monitor.sv
// Runtime output checker: recomputes the golden stage output, counts mismatches, raises a sticky alarm.
module hwt_output_monitor
   import hwt_mon_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int WINDOW       = WINDOW_DEF,
   parameter int ALARM_THRESH = THRESH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             y,
   input  logic             clear,
   output logic             mismatch,
   output logic             alarm,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [3:0]       last_vec,
   output logic [1:0]       state
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   mon_state_t st_q, st_d;
   logic [3:0] vec_p0;
   logic       y_p0;
   logic       vld_p0;
   logic       cmp_err;
   logic       win_clr;
   logic       hit;

   // stage 1: capture tapped inputs and observed output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_p0 <= '0;
         y_p0   <= 1'b0;
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= en;
         if (en) begin
            vec_p0 <= {a, b, c, d};
            y_p0   <= y;
         end
      end
   end

   assign cmp_err = vld_p0 & (golden_y(vec_p0[3], vec_p0[2], vec_p0[1], vec_p0[0]) != y_p0);

   // stage 2: compare against golden and update counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch   <= 1'b0;
         err_cnt    <= '0;
         sample_cnt <= '0;
         last_vec   <= '0;
      end else begin
         mismatch <= cmp_err;
         if (vld_p0) sample_cnt <= sat_inc(sample_cnt);
         if (cmp_err) begin
            err_cnt  <= sat_inc(err_cnt);
            last_vec <= vec_p0;
         end
      end
   end

   // leaving MON after the pipeline drains starts the next session with a fresh window
   assign win_clr = clear | ((st_q == ST_MON) & ~en & ~vld_p0);

   hwt_window_ctr #(
      .WINDOW       (WINDOW),
      .ALARM_THRESH (ALARM_THRESH)
   ) u_win (
      .clk     (clk),
      .rst     (rst),
      .cmp_vld (vld_p0),
      .cmp_err (cmp_err),
      .clr     (win_clr),
      .hit     (hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st_q <= ST_IDLE;
      else     st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE:  if (en) st_d = ST_MON;
         ST_MON: begin
            if (hit)                st_d = ST_ALARM;
            else if (!en && !vld_p0) st_d = ST_IDLE;
         end
         ST_ALARM: if (clear) st_d = en ? ST_MON : ST_IDLE;
         default:  st_d = ST_IDLE;
      endcase
   end

   assign alarm = (st_q == ST_ALARM);
   assign state = st_q;

endmodule

// File: tb/tb_hwt_output_monitor.sv
// Directed bench for hwt_output_monitor: default instance plus a CNT_W=4 instance for saturation.
module tb_hwt_output_monitor;

   logic clk = 1'b0;
   logic rst, en, a, b, c, d, y, clear;

   logic       mis8, al8;
   logic [7:0] ec8, sc8;
   logic [3:0] lv8;
   logic [1:0] st8;
   logic       mis4, al4;
   logic [3:0] ec4, sc4;
   logic [3:0] lv4;
   logic [1:0] st4;

   int nvec = 0;
   int nerr = 0;

   // truth table of d & ((a&b)|c) indexed by {a,b,c,d}: ones at 3, 7, 11, 13, 15
   localparam logic [15:0] GOLD = 16'hA888;
   localparam logic [3:0]  V_BAD = 4'b0011;
   localparam logic [3:0]  V_OK  = 4'b0000;
   localparam logic [3:0]  V_ALL = 4'b1111;

   always #5 clk = ~clk;

   hwt_output_monitor u_dut8 (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d), .y(y), .clear(clear),
      .mismatch(mis8), .alarm(al8), .err_cnt(ec8), .sample_cnt(sc8), .last_vec(lv8), .state(st8)
   );

   hwt_output_monitor #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d), .y(y), .clear(clear),
      .mismatch(mis4), .alarm(al4), .err_cnt(ec4), .sample_cnt(sc4), .last_vec(lv4), .state(st4)
   );

   task automatic step(input logic [3:0] v, input logic yv, input logic e, input logic clr);
      {a, b, c, d} = v;
      y     = yv;
      en    = e;
      clear = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; clear = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 5; i++) step(V_ALL, 1'b0, 1'b1, 1'b0);
      nvec++; if (ec8 !== 8'd4) begin nerr++; $display("FAIL pre_reset_err: got %0d expected 4", ec8); end
      nvec++; if (al8 !== 1'b1) begin nerr++; $display("FAIL pre_reset_alarm: got %0b expected 1", al8); end
      #2;
      rst = 1'b1; {a, b, c, d} = 4'b1010; y = 1'b1; en = 1'b1;
      #1;
      nvec++; if (al8 !== 1'b0 || al4 !== 1'b0) begin nerr++; $display("FAIL reset_alarm: got %0b/%0b expected 0/0", al8, al4); end
      nvec++; if (mis8 !== 1'b0 || mis4 !== 1'b0) begin nerr++; $display("FAIL reset_mismatch: got %0b/%0b expected 0/0", mis8, mis4); end
      nvec++; if (ec8 !== 8'd0 || ec4 !== 4'd0) begin nerr++; $display("FAIL reset_err_cnt: got %0d/%0d expected 0/0", ec8, ec4); end
      nvec++; if (sc8 !== 8'd0 || sc4 !== 4'd0) begin nerr++; $display("FAIL reset_sample_cnt: got %0d/%0d expected 0/0", sc8, sc4); end
      nvec++; if (st8 !== 2'd0 || st4 !== 2'd0) begin nerr++; $display("FAIL reset_state: got %0d/%0d expected 0/0", st8, st4); end
      @(posedge clk);
      #1;
      rst = 1'b0; en = 1'b0; clear = 1'b0;
   endtask

   task automatic test_clean_sweep();
      logic [15:0] g;
      g = GOLD;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(4'(i), g[i], 1'b1, 1'b0);
         nvec++; if (mis8 !== 1'b0) begin nerr++; $display("FAIL clean_mismatch[%0d]: got %0b expected 0", i, mis8); end
      end
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (mis8 !== 1'b0) begin nerr++; $display("FAIL clean_mismatch_last: got %0b expected 0", mis8); end
      nvec++; if (ec8 !== 8'd0) begin nerr++; $display("FAIL clean_err_cnt: got %0d expected 0", ec8); end
      nvec++; if (sc8 !== 8'd16) begin nerr++; $display("FAIL clean_sample_cnt: got %0d expected 16", sc8); end
      nvec++; if (sc4 !== 4'd15) begin nerr++; $display("FAIL clean_sample_cnt_w4: got %0d expected 15", sc4); end
      nvec++; if (st8 !== 2'd1) begin nerr++; $display("FAIL clean_state_mon: got %0d expected 1", st8); end
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (st8 !== 2'd0) begin nerr++; $display("FAIL clean_state_idle: got %0d expected 0", st8); end
   endtask

   task automatic test_single_fault();
      do_reset();
      step(V_ALL, 1'b0, 1'b1, 1'b0);
      nvec++; if (mis8 !== 1'b0) begin nerr++; $display("FAIL single_early: got %0b expected 0", mis8); end
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (mis8 !== 1'b1) begin nerr++; $display("FAIL single_mismatch: got %0b expected 1", mis8); end
      nvec++; if (ec8 !== 8'd1) begin nerr++; $display("FAIL single_err_cnt: got %0d expected 1", ec8); end
      nvec++; if (lv8 !== 4'b1111 || lv4 !== 4'b1111) begin nerr++; $display("FAIL single_last_vec: got %b/%b expected 1111", lv8, lv4); end
      nvec++; if (al8 !== 1'b0) begin nerr++; $display("FAIL single_alarm: got %0b expected 0", al8); end
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (mis8 !== 1'b0) begin nerr++; $display("FAIL single_pulse_width: got %0b expected 0", mis8); end
      nvec++; if (st8 !== 2'd0) begin nerr++; $display("FAIL single_state: got %0d expected 0", st8); end
   endtask

   task automatic test_trigger();
      do_reset();
      step(V_BAD, 1'b0, 1'b1, 1'b0);
      step(V_OK,  1'b0, 1'b1, 1'b0);
      step(V_BAD, 1'b0, 1'b1, 1'b0);
      step(V_BAD, 1'b0, 1'b1, 1'b0);
      step(V_OK,  1'b0, 1'b1, 1'b0);
      step(V_BAD, 1'b0, 1'b1, 1'b0);
      nvec++; if (al8 !== 1'b0) begin nerr++; $display("FAIL trig_alarm_early: got %0b expected 0", al8); end
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (mis8 !== 1'b1) begin nerr++; $display("FAIL trig_mismatch: got %0b expected 1", mis8); end
      nvec++; if (al8 !== 1'b1) begin nerr++; $display("FAIL trig_alarm: got %0b expected 1", al8); end
      nvec++; if (st8 !== 2'd2) begin nerr++; $display("FAIL trig_state: got %0d expected 2", st8); end
      step(V_OK, 1'b0, 1'b0, 1'b0);
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (al8 !== 1'b1 || st8 !== 2'd2) begin nerr++; $display("FAIL trig_sticky: got alarm %0b state %0d expected 1 2", al8, st8); end
      step(V_OK, 1'b0, 1'b0, 1'b1);
      clear = 1'b0;
      nvec++; if (st8 !== 2'd0) begin nerr++; $display("FAIL trig_clear_state: got %0d expected 0", st8); end
      nvec++; if (al8 !== 1'b0) begin nerr++; $display("FAIL trig_clear_alarm: got %0b expected 0", al8); end
      nvec++; if (ec8 !== 8'd4) begin nerr++; $display("FAIL trig_err_kept: got %0d expected 4", ec8); end
   endtask

   task automatic test_window_boundary();
      do_reset();
      for (int i = 0; i < 13; i++) step(V_OK, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(V_BAD, 1'b0, 1'b1, 1'b0);
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (mis8 !== 1'b1) begin nerr++; $display("FAIL win_mismatch16: got %0b expected 1", mis8); end
      nvec++; if (al8 !== 1'b0) begin nerr++; $display("FAIL win_alarm: got %0b expected 0", al8); end
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (ec8 !== 8'd4) begin nerr++; $display("FAIL win_err_cnt: got %0d expected 4", ec8); end
      nvec++; if (st8 !== 2'd0) begin nerr++; $display("FAIL win_state: got %0d expected 0", st8); end
   endtask

   task automatic test_clear_collision();
      do_reset();
      for (int i = 0; i < 4; i++) step(V_BAD, 1'b0, 1'b1, 1'b0);
      step(V_OK, 1'b0, 1'b0, 1'b1);
      clear = 1'b0;
      nvec++; if (mis8 !== 1'b1) begin nerr++; $display("FAIL clr_mismatch: got %0b expected 1", mis8); end
      nvec++; if (al8 !== 1'b0) begin nerr++; $display("FAIL clr_alarm: got %0b expected 0", al8); end
      nvec++; if (st8 !== 2'd1) begin nerr++; $display("FAIL clr_state: got %0d expected 1", st8); end
      nvec++; if (ec8 !== 8'd4) begin nerr++; $display("FAIL clr_err_cnt: got %0d expected 4", ec8); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) step(V_ALL, 1'b0, 1'b1, 1'b0);
      step(V_OK, 1'b0, 1'b0, 1'b0);
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (ec4 !== 4'd15) begin nerr++; $display("FAIL sat_err_cnt_w4: got %0d expected 15", ec4); end
      nvec++; if (sc4 !== 4'd15) begin nerr++; $display("FAIL sat_sample_cnt_w4: got %0d expected 15", sc4); end
      nvec++; if (ec8 !== 8'd20 || sc8 !== 8'd20) begin nerr++; $display("FAIL sat_cnt_w8: got %0d/%0d expected 20/20", ec8, sc8); end
      nvec++; if (al4 !== 1'b1 || st4 !== 2'd2) begin nerr++; $display("FAIL sat_alarm: got alarm %0b state %0d expected 1 2", al4, st4); end
      step(V_ALL, 1'b0, 1'b1, 1'b0);
      step(V_OK, 1'b0, 1'b0, 1'b0);
      step(V_OK, 1'b0, 1'b0, 1'b0);
      nvec++; if (ec4 !== 4'd15 || sc4 !== 4'd15) begin nerr++; $display("FAIL sat_hold: got %0d/%0d expected 15/15", ec4, sc4); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int i = 0; i < 3; i++) step(V_ALL, 1'b0, 1'b1, 1'b0);
      #1;
      rst = 1'b1; en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(V_OK, 1'b0, 1'b0, 1'b0);
         nvec++; if (mis8 !== 1'b0 || mis4 !== 1'b0) begin nerr++; $display("FAIL rstmid_mismatch[%0d]: got %0b/%0b expected 0/0", i, mis8, mis4); end
      end
      nvec++; if (ec8 !== 8'd0) begin nerr++; $display("FAIL rstmid_err_cnt: got %0d expected 0", ec8); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clear = 1'b0;
      {a, b, c, d} = 4'b0000; y = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_clean_sweep();
      test_single_fault();
      test_trigger();
      test_window_boundary();
      test_clear_collision();
      test_saturation();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
